// File: rtl/lfsr_pkt_checker.sv
// AXI-Stream sink that regenerates the num_gen LFSR stream and counts errored beats and packets.
// Optional macro LFSR_CHK_STALL_EN: throttle TREADY to alternate cycles to exercise upstream backpressure.
module lfsr_pkt_checker #(
    parameter int                  TDATAW       = 32,
    parameter int                  TDESTW       = 4,
    parameter int                  LFSR_DW      = 8,
    parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = 8'h01,
    parameter int                  NUM_PACKETS  = 4,
    parameter int                  PKT_BEATS    = 4,
    parameter logic [TDESTW-1:0]   EXP_DEST     = 4'd3
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    output logic [15:0]       PKT_CNT,
    output logic [15:0]       ERR_CNT,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST
);

    localparam int                BW         = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [BW-1:0]     LAST_BEAT  = BW'(PKT_BEATS - 1);
    localparam logic [15:0]       PKT_TARGET = 16'(NUM_PACKETS);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [LFSR_DW-1:0]   lfsr;
    logic [LFSR_DW-1:0]   lfsr_next;
    logic [BW-1:0]        beat_cnt;
    logic [BW-1:0]        beat_next;
    logic [15:0]          pkt_next;
    logic [15:0]          err_next;
    logic                 done_next;
    logic                 tready_next;
    logic                 start_clr;
    logic                 accept;
    logic                 at_last_beat;
    logic                 beat_err;
    logic                 stall_ok;
    logic [TDATAW-1:0]    exp_data;

    assign accept       = AXIS_S_TVALID & AXIS_S_TREADY;
    assign at_last_beat = (beat_cnt == LAST_BEAT);
    assign exp_data     = TDATAW'(lfsr);
    assign beat_err     = (AXIS_S_TDATA != exp_data) || (AXIS_S_TDEST != EXP_DEST) ||
                          (AXIS_S_TLAST != at_last_beat);
    assign BUSY         = (state == RECV);

`ifdef LFSR_CHK_STALL_EN
    logic toggle;
    logic toggle_next;

    // Toggle restarts at zero on START so the first RECV cycle is always ready.
    assign toggle_next = start_clr ? 1'b0 : ~toggle;
    assign stall_ok    = ~toggle_next;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            toggle <= 1'b0;
        end else begin
            toggle <= toggle_next;
        end
    end
`else
    assign stall_ok = 1'b1;
`endif

    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        beat_next  = beat_cnt;
        pkt_next   = PKT_CNT;
        err_next   = ERR_CNT;
        done_next  = 1'b0;
        start_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_next = RECV;
                    pkt_next   = 16'd0;
                    err_next   = 16'd0;
                    beat_next  = '0;
                    start_clr  = 1'b1;
                end
            end
            RECV: begin
                if (accept) begin
                    // Taps 7,5,4,3: only the 8-bit LFSR is supported.
                    lfsr_next = {lfsr[LFSR_DW-2:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    if (beat_err && (ERR_CNT != 16'hFFFF)) begin
                        err_next = ERR_CNT + 16'd1;
                    end
                    // Received TLAST, not the expected length, closes a packet.
                    if (AXIS_S_TLAST) begin
                        beat_next = '0;
                        pkt_next  = PKT_CNT + 16'd1;
                        if ((PKT_CNT + 16'd1) == PKT_TARGET) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else if (!at_last_beat) begin
                        beat_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        tready_next = (state_next == RECV) && stall_ok;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            lfsr          <= LFSR_DEFAULT;
            beat_cnt      <= '0;
            PKT_CNT       <= 16'd0;
            ERR_CNT       <= 16'd0;
            DONE          <= 1'b0;
            AXIS_S_TREADY <= 1'b0;
        end else begin
            state         <= state_next;
            lfsr          <= lfsr_next;
            beat_cnt      <= beat_next;
            PKT_CNT       <= pkt_next;
            ERR_CNT       <= err_next;
            DONE          <= done_next;
            AXIS_S_TREADY <= tready_next;
        end
    end

endmodule

// File: tb/tb_lfsr_pkt_checker.sv
// Directed bench for lfsr_pkt_checker: per-beat vector tables plus hand-written reset/idle sequences.
// Also builds with LFSR_CHK_STALL_EN defined, where TREADY pacing expectations change.
module tb_lfsr_pkt_checker;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        TVALID = 1'b0;
    logic        TLAST = 1'b0;
    logic [31:0] TDATA = 32'd0;
    logic [3:0]  TDEST = 4'd0;
    logic        BUSY;
    logic        DONE;
    logic        TREADY;
    logic [15:0] PKT_CNT;
    logic [15:0] ERR_CNT;

    int checks = 0;
    int fails = 0;
    logic [7:0] model_lfsr = 8'h01;
    int busy_cycles = 0;
    int hist_n = 4;
    logic [3:0] tready_hist = 4'd0;

    typedef struct {
        logic        start;
        logic        bad;
        logic        last;
        logic [3:0]  dest;
        logic [15:0] exp_err;
        logic [15:0] exp_pkt;
        logic        exp_done;
    } vec_t;

    vec_t tbl[$];

    lfsr_pkt_checker dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .START        (START),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .PKT_CNT      (PKT_CNT),
        .ERR_CNT      (ERR_CNT),
        .AXIS_S_TVALID(TVALID),
        .AXIS_S_TREADY(TREADY),
        .AXIS_S_TDATA (TDATA),
        .AXIS_S_TLAST (TLAST),
        .AXIS_S_TDEST (TDEST)
    );

    always #5 CLK = ~CLK;

    // Tracks how long each run stays busy and the TREADY pattern of its first four cycles.
    always @(negedge CLK) begin
        if (BUSY) begin
            busy_cycles++;
            if (hist_n < 4) begin
                tready_hist[hist_n] = TREADY;
                hist_n++;
            end
        end
    end

    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addBeat(input logic start, input logic bad, input logic last, input logic [3:0] dest,
                           input logic [15:0] err, input logic [15:0] pkt, input logic done);
        tbl.push_back('{start: start, bad: bad, last: last, dest: dest,
                        exp_err: err, exp_pkt: pkt, exp_done: done});
    endtask

    task automatic addPacket(input logic [15:0] err, input logic [15:0] pkt_before, input logic done);
        for (int b = 0; b < 4; b++) begin
            addBeat(1'b0, 1'b0, b == 3, 4'd3, err,
                    (b == 3) ? pkt_before + 16'd1 : pkt_before, (b == 3) && done);
        end
    endtask

    task automatic pulseStart();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Presents every table entry as one beat and checks counters one edge after acceptance.
    task automatic applyStimulus(input string tag);
        int waited;
        for (int i = 0; i < tbl.size(); i++) begin
            START  = tbl[i].start;
            TDATA  = tbl[i].bad ? ((model_lfsr == 8'hFF) ? 32'hFE : 32'hFF) : {24'd0, model_lfsr};
            TLAST  = tbl[i].last;
            TDEST  = tbl[i].dest;
            TVALID = 1'b1;
            waited = 0;
            while (!TREADY && waited < 8) begin
                @(negedge CLK);
                waited++;
            end
            if (!TREADY) begin
                checkOutput($sformatf("%s tready timeout beat %0d", tag, i), {31'd0, TREADY}, 32'd1);
                break;
            end
            @(negedge CLK);
            START = 1'b0;
            model_lfsr = lfsrStep(model_lfsr);
            checkOutput($sformatf("%s err beat %0d", tag, i), {16'd0, ERR_CNT}, {16'd0, tbl[i].exp_err});
            checkOutput($sformatf("%s pkt beat %0d", tag, i), {16'd0, PKT_CNT}, {16'd0, tbl[i].exp_pkt});
            checkOutput($sformatf("%s done beat %0d", tag, i), {31'd0, DONE}, {31'd0, tbl[i].exp_done});
            if (tbl[i].exp_done) begin
                checkOutput($sformatf("%s tready at end", tag), {31'd0, TREADY}, 32'd0);
                checkOutput($sformatf("%s busy at end", tag), {31'd0, BUSY}, 32'd0);
            end
        end
        TVALID = 1'b0;
        TLAST  = 1'b0;
        START  = 1'b0;
        tbl.delete();
    endtask

    task automatic finishRun(input string tag, input logic [15:0] pkt, input logic [15:0] err);
        @(negedge CLK);
        checkOutput($sformatf("%s done drops", tag), {31'd0, DONE}, 32'd0);
        checkOutput($sformatf("%s idle tready", tag), {31'd0, TREADY}, 32'd0);
        checkOutput($sformatf("%s idle busy", tag), {31'd0, BUSY}, 32'd0);
        checkOutput($sformatf("%s final pkt", tag), {16'd0, PKT_CNT}, {16'd0, pkt});
        checkOutput($sformatf("%s final err", tag), {16'd0, ERR_CNT}, {16'd0, err});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values.
        repeat (2) @(negedge CLK);
        checkOutput("reset busy", {31'd0, BUSY}, 32'd0);
        checkOutput("reset done", {31'd0, DONE}, 32'd0);
        checkOutput("reset tready", {31'd0, TREADY}, 32'd0);
        checkOutput("reset pkt", {16'd0, PKT_CNT}, 32'd0);
        checkOutput("reset err", {16'd0, ERR_CNT}, 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);

        // Clean run, with a START during RECV that must be ignored.
        busy_cycles = 0;
        hist_n = 0;
        pulseStart();
        for (int p = 0; p < 4; p++) addPacket(16'd0, 16'(p), p == 3);
        tbl[9].start = 1'b1;
        applyStimulus("clean");
        finishRun("clean", 16'd4, 16'd0);
`ifdef LFSR_CHK_STALL_EN
        checkOutput("clean busy cycles", busy_cycles, 32'd31);
        checkOutput("clean tready pattern", {28'd0, tready_hist}, 32'h5);
`else
        checkOutput("clean busy cycles", busy_cycles, 32'd16);
        checkOutput("clean tready pattern", {28'd0, tready_hist}, 32'hF);
`endif

        // Beats offered while idle must be refused and leave the counters alone.
        TVALID = 1'b1;
        TDATA  = 32'h55;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checkOutput("idle refuses tready", {31'd0, TREADY}, 32'd0);
            checkOutput("idle holds pkt", {16'd0, PKT_CNT}, 32'd4);
        end
        TVALID = 1'b0;

        // One corrupted data beat; the LFSR keeps stepping so later beats pass.
        pulseStart();
        checkOutput("baddata pkt cleared", {16'd0, PKT_CNT}, 32'd0);
        addPacket(16'd0, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd0, 16'd1, 1'b0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd0, 16'd1, 1'b0);
        addBeat(1'b0, 1'b1, 1'b0, 4'd3, 16'd1, 16'd1, 1'b0);
        addBeat(1'b0, 1'b0, 1'b1, 4'd3, 16'd1, 16'd2, 1'b0);
        addPacket(16'd1, 16'd2, 1'b0);
        addPacket(16'd1, 16'd3, 1'b1);
        applyStimulus("baddata");
        finishRun("baddata", 16'd4, 16'd1);

        // Early TLAST on beat 1 closes a two-beat packet with one framing error.
        pulseStart();
        checkOutput("early err cleared", {16'd0, ERR_CNT}, 32'd0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd0, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b1, 4'd3, 16'd1, 16'd1, 1'b0);
        addPacket(16'd1, 16'd1, 1'b0);
        addPacket(16'd1, 16'd2, 1'b0);
        addPacket(16'd1, 16'd3, 1'b1);
        applyStimulus("early");
        finishRun("early", 16'd4, 16'd1);

        // Wrong TDEST on every beat, then a clean run continuing the LFSR.
        pulseStart();
        for (int b = 0; b < 16; b++) begin
            addBeat(1'b0, 1'b0, (b % 4) == 3, 4'd2, 16'(b + 1),
                    16'((b + 1) / 4), b == 15);
        end
        applyStimulus("dest");
        finishRun("dest", 16'd4, 16'd16);
        pulseStart();
        checkOutput("dest rerun err cleared", {16'd0, ERR_CNT}, 32'd0);
        for (int p = 0; p < 4; p++) addPacket(16'd0, 16'(p), p == 3);
        applyStimulus("rerun");
        finishRun("rerun", 16'd4, 16'd0);

        // Missing TLAST: beats 3 and 4 err, beat 5 TLAST matches the saturated count.
        pulseStart();
        for (int b = 0; b < 3; b++) addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd0, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd1, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd2, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b1, 4'd3, 16'd2, 16'd1, 1'b0);
        addPacket(16'd2, 16'd1, 1'b0);
        addPacket(16'd2, 16'd2, 1'b0);
        addPacket(16'd2, 16'd3, 1'b1);
        applyStimulus("longpkt");
        finishRun("longpkt", 16'd4, 16'd2);

        // Asynchronous reset in the middle of packet 2, then a fresh run from the seed.
        pulseStart();
        addPacket(16'd0, 16'd0, 1'b0);
        addBeat(1'b0, 1'b0, 1'b0, 4'd3, 16'd0, 16'd1, 1'b0);
        addBeat(1'b0, 1'b1, 1'b0, 4'd3, 16'd1, 16'd1, 1'b0);
        applyStimulus("prereset");
        #2 RST_N = 1'b0;
        #1;
        checkOutput("midreset busy", {31'd0, BUSY}, 32'd0);
        checkOutput("midreset tready", {31'd0, TREADY}, 32'd0);
        checkOutput("midreset done", {31'd0, DONE}, 32'd0);
        checkOutput("midreset pkt", {16'd0, PKT_CNT}, 32'd0);
        checkOutput("midreset err", {16'd0, ERR_CNT}, 32'd0);
        model_lfsr = 8'h01;
        @(negedge CLK);
        RST_N = 1'b1;
        pulseStart();
        for (int p = 0; p < 4; p++) addPacket(16'd0, 16'(p), p == 3);
        applyStimulus("postreset");
        finishRun("postreset", 16'd4, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
